map_ram_arbiter: RTL and testbench

MAP_RAM_ARBITER -- requirements
Module: map_ram_arbiter

---
 rtl/vga_pkg.sv | 27 ++
 rtl/map_wr_fifo.sv | 73 +++++++
 rtl/map_ram_arbiter.sv | 135 +++++++++++++
 tb/tb_map_ram_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared definitions for the tile-map RAM arbiter.
//            Holds the RAM-port FSM state encoding, the default address and
//            data widths, and the tile and map geometry constants.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

    // A 640x480 screen of 32-pixel tiles gives a 20x15 map, which fits in 9 bits.
    localparam int c_tile_size      = 32;
    localparam int c_map_cols       = 20;
    localparam int c_map_rows       = 15;
    localparam int c_default_addr_w = 9;
    localparam int c_default_data_w = 4;

    // RAM-port operation issued at the most recent clock edge.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_t;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/map_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : map_wr_fifo
// Purpose  : Synchronous write buffer holding pending tile-map writes.
//            Entries leave in strict arrival order.
// Ports    : clk, rst_n   clock and asynchronous active-low reset
//            push, wdata  enqueue one entry (ignored while full)
//            pop, rdata   dequeue head entry (ignored while empty);
//                         rdata always shows the current head
//            full, empty, level  occupancy status, all from registered level
// Revision : 1.0  initial release
// ============================================================================
module map_wr_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == LVL_W'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : map_wr_fifo
`default_nettype wire

// File: rtl/map_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : map_ram_arbiter
// Purpose  : Shares one single-port tile-map RAM between the video renderer
//            (reads, absolute priority, two-cycle latency) and the game logic
//            (writes, buffered in map_wr_fifo and drained when the port is
//            free). No read-after-write forwarding is performed.
// Ports    : clock_25, reset_key   pixel clock, async active-low reset
//            video_on              active-video flag
//            rd_req/rd_addr        renderer read request (always accepted)
//            rd_data/rd_valid      read return, two cycles after the request
//            wr_valid/wr_addr/wr_data/wr_ready  buffered write interface
//            fifo_level            number of writes waiting
//            ram_addr/ram_we/ram_wdata  registered RAM port
//            ram_rdata             RAM read data, one cycle after ram_addr
// Config   : MAP_ARB_BLANK_WRITE_EN - when defined, buffered writes drain only
//            while video_on is low.
// Revision : 1.0  initial release
// ============================================================================
module map_ram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = c_default_addr_w,
    parameter int DATA_W     = c_default_data_w,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock_25,
    input  logic                          reset_key,
    input  logic                          video_on,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    input  logic                          wr_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic                          ram_we,
    output logic [DATA_W-1:0]             ram_wdata,
    input  logic [DATA_W-1:0]             ram_rdata
);

    localparam int ENTRY_W = ADDR_W + DATA_W;

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic                r_rd_valid;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_ram_we;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_drain_ok;
    logic [ENTRY_W-1:0]  w_head;

`ifdef MAP_ARB_BLANK_WRITE_EN
    assign w_drain_ok = !video_on;
`else
    assign w_drain_ok = 1'b1;
    logic w_unused_video_on;
    assign w_unused_video_on = video_on;
`endif

    // wr_ready comes from the registered level only, so a full buffer refuses
    // a push even on a cycle where an entry is popped.
    assign wr_ready = !w_full;
    assign w_push   = wr_valid && wr_ready;

    map_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk   (clock_25),
        .rst_n (reset_key),
        .push  (w_push),
        .wdata ({wr_addr, wr_data}),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    // Reads win unconditionally; a pending write waits for a free cycle.
    always_comb begin
        w_state_next = ST_IDLE;
        w_pop        = 1'b0;
        if (rd_req) begin
            w_state_next = ST_READ;
        end else if (!w_empty && w_drain_ok) begin
            w_state_next = ST_WRITE;
            w_pop        = 1'b1;
        end
    end

    always_ff @(posedge clock_25 or negedge reset_key) begin
        if (!reset_key) begin
            r_state     <= ST_IDLE;
            r_rd_valid  <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_state    <= w_state_next;
            // RAM data for a READ issued last edge is presented this edge.
            r_rd_valid <= (r_state == ST_READ);
            r_ram_we   <= (w_state_next == ST_WRITE);
            case (w_state_next)
                ST_READ: begin
                    r_ram_addr <= rd_addr;
                end
                ST_WRITE: begin
                    r_ram_addr  <= w_head[ENTRY_W-1:DATA_W];
                    r_ram_wdata <= w_head[DATA_W-1:0];
                end
                default: begin
                    r_ram_addr  <= r_ram_addr;
                    r_ram_wdata <= r_ram_wdata;
                end
            endcase
        end
    end

    assign rd_data   = ram_rdata;
    assign rd_valid  = r_rd_valid;
    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;
    assign ram_wdata = r_ram_wdata;

endmodule : map_ram_arbiter
`default_nettype wire

// File: tb/tb_map_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_ram_arbiter
// Purpose  : Self-checking bench for map_ram_arbiter. A queue-based reference
//            model predicts every RAM-port operation, read return and buffer
//            occupancy; the tile RAM itself is modelled inside the bench.
// Revision : 1.0  initial release
// ============================================================================
module tb_map_ram_arbiter;

    localparam int DEPTH = 4;

    logic       clock_25 = 1'b0;
    logic       reset_key;
    logic       video_on;
    logic       rd_req;
    logic [8:0] rd_addr;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic       wr_valid;
    logic [8:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ready;
    logic [2:0] fifo_level;
    logic [8:0] ram_addr;
    logic       ram_we;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Tile RAM contents and the model's view of what they should be.
    logic [3:0] ram_mem [512];
    logic [3:0] shadow  [512];

    // Reference model state.
    logic [8:0] q_a [$];
    logic [3:0] q_d [$];
    logic [8:0] m_addr;
    logic [3:0] m_wdata;
    bit         m_we;
    bit         m_prev_read;
    logic [3:0] m_prev_cap;

    always #20 clock_25 = ~clock_25;

    map_ram_arbiter dut (
        .clock_25   (clock_25),
        .reset_key  (reset_key),
        .video_on   (video_on),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .fifo_level (fifo_level),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge including the synchronous single-port RAM behaviour.
    task automatic tick();
        bit         we_s = ram_we;
        logic [8:0] a_s  = ram_addr;
        logic [3:0] d_s  = ram_wdata;
        @(posedge clock_25);
        ram_rdata = ram_mem[a_s];
        if (we_s) ram_mem[a_s] = d_s;
        #1;
    endtask

    task automatic check_outputs(input bit exp_rv, input logic [3:0] exp_rd);
        chk("ram_we", ram_we, m_we);
        chk("ram_addr", ram_addr, m_addr);
        chk("ram_wdata", ram_wdata, m_wdata);
        chk("rd_valid", rd_valid, exp_rv);
        if (exp_rv) chk("rd_data", rd_data, exp_rd);
        chk("fifo_level", fifo_level, q_a.size());
        chk("wr_ready", wr_ready, q_a.size() < DEPTH);
    endtask

    // One functional cycle: drive inputs, predict, clock, compare.
    task automatic cyc(input bit rr, input int ra, input bit wv, input int wa,
                       input int wd, input bit vo);
        int         pre      = q_a.size();
        bit         nxt_read = 1'b0;
        logic [3:0] cap      = '0;
        bit         blank_ok;
        bit         exp_rv;
        logic [3:0] exp_rd;
        rd_req   = rr;
        rd_addr  = ra[8:0];
        wr_valid = wv;
        wr_addr  = wa[8:0];
        wr_data  = wd[3:0];
        video_on = vo;
`ifdef MAP_ARB_BLANK_WRITE_EN
        blank_ok = !vo;
`else
        blank_ok = 1'b1;
`endif
        m_we = 1'b0;
        if (rr) begin
            m_addr   = ra[8:0];
            nxt_read = 1'b1;
            cap      = shadow[ra[8:0]];
        end else if (pre > 0 && blank_ok) begin
            m_addr  = q_a.pop_front();
            m_wdata = q_d.pop_front();
            m_we    = 1'b1;
            shadow[m_addr] = m_wdata;
        end
        if (wv && pre < DEPTH) begin
            q_a.push_back(wa[8:0]);
            q_d.push_back(wd[3:0]);
        end
        exp_rv      = m_prev_read;
        exp_rd      = m_prev_cap;
        m_prev_read = nxt_read;
        m_prev_cap  = cap;
        tick();
        check_outputs(exp_rv, exp_rd);
    endtask

    task automatic rst_pulse(input int n);
        reset_key = 1'b0;
        rd_req    = 1'b0;
        wr_valid  = 1'b0;
        q_a.delete();
        q_d.delete();
        m_addr      = '0;
        m_wdata     = '0;
        m_we        = 1'b0;
        m_prev_read = 1'b0;
        m_prev_cap  = '0;
        #1;
        for (int i = 0; i < n; i++) begin
            tick();
            check_outputs(1'b0, 4'h0);
        end
        reset_key = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        int diffs;
        reset_key = 1'b0;
        video_on  = 1'b0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        ram_rdata = '0;
        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = 4'($urandom_range(0, 15));
            shadow[i]  = ram_mem[i];
        end

        // Reset state.
        rst_pulse(2);
        idle(1);

        // Single read of a known tile.
        ram_mem[37] = 4'hA;
        shadow[37]  = 4'hA;
        cyc(1'b1, 37, 1'b0, 0, 0, 1'b0);
        idle(3);

        // Single write drains on the following cycle.
        cyc(1'b0, 0, 1'b1, 5, 3, 1'b0);
        idle(3);

        // Reads hold off four buffered writes; a fifth is refused.
        for (int i = 0; i < 4; i++) cyc(1'b1, 100 + i, 1'b1, 200 + i, i + 6, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 300 + i, 1'b1, 250, 15, 1'b0);
        idle(6);

        // Same-cycle push and pop at level 2, then at level 4.
        for (int i = 0; i < 2; i++) cyc(1'b1, 40 + i, 1'b1, 60 + i, i + 1, 1'b0);
        cyc(1'b0, 0, 1'b1, 62, 9, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b1, 50 + i, 1'b1, 63 + i, i + 10, 1'b0);
        cyc(1'b0, 0, 1'b1, 70, 12, 1'b0);
        idle(5);

        // Read of an address still buffered returns old RAM contents.
        cyc(1'b1, 1, 1'b1, 80, 5, 1'b0);
        cyc(1'b1, 80, 1'b0, 0, 0, 1'b0);
        idle(4);

        // Writes wait while video is active, drain once it falls.
        cyc(1'b1, 2, 1'b1, 90, 7, 1'b1);
        cyc(1'b0, 0, 1'b0, 0, 0, 1'b1);
        cyc(1'b0, 0, 1'b0, 0, 0, 1'b1);
        cyc(1'b0, 0, 1'b0, 0, 0, 1'b0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 511),
                $urandom_range(0, 1) == 1, $urandom_range(0, 511),
                $urandom_range(0, 15), $urandom_range(0, 3) == 0);
        end
        idle(6);

        // Reset with three writes buffered discards them.
        for (int i = 0; i < 3; i++) cyc(1'b1, 10 + i, 1'b1, 400 + i, 15 - i, 1'b0);
        rst_pulse(2);
        idle(5);
        diffs = 0;
        for (int i = 0; i < 512; i++) if (ram_mem[i] !== shadow[i]) diffs++;
        chk("ram_contents_diffs", diffs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_map_ram_arbiter
`default_nettype wire
